// File: rtl/fp_pkg.sv
// Shared widths, state encoding and IEEE-754 single-precision constants
// for the normalize-and-pack stage.
package fp_pkg;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;
endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over a 24-bit significand; an all-zero
// input reports 24.
module fp_lzc (
    input  logic [23:0] din,
    output logic [4:0]  cnt
);
    always_comb begin
        cnt = 5'd24;
        // Scanning upward lets the highest set bit win.
        for (int i = 0; i < 24; i++) begin
            if (din[i]) cnt = 5'(23 - i);
        end
    end
endmodule

// File: rtl/fp_normalize_pack.sv
// Renormalizes a raw add/sub result and packs it as IEEE-754 single.
// FP_NORM_FAST_SHIFT_EN selects a one-cycle LZC shifter instead of serial shifts.
module fp_normalize_pack
    import fp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_W-1:0]     in_exp,
    input  logic [MAN_W+1:0]     in_mant,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_word,
    output logic                 out_zero,
    output logic                 out_ovf,
    output logic                 out_unf
);
    localparam logic [EXP_W:0] EXP_SAT = (EXP_W+1)'(EXP_MAX);

    state_t             state, state_nxt;
    logic               sign_r;
    logic [EXP_W:0]     exp_r;
    logic [MAN_W+1:0]   mant_r;
    logic               zero_r, ovf_r, unf_r;
    logic [EXP_W:0]     exp_inc;

    assign exp_inc = exp_r + 1'b1;

`ifdef FP_NORM_FAST_SHIFT_EN
    logic [4:0] lz;

    fp_lzc u_lzc (
        .din (mant_r[MAN_W:0]),
        .cnt (lz)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = NORM;
`ifdef FP_NORM_FAST_SHIFT_EN
            NORM: state_nxt = DONE;
`else
            NORM: if (mant_r == '0 || exp_r == EXP_SAT || mant_r[MAN_W+1] ||
                      mant_r[MAN_W] || exp_r <= 9'd1)
                      state_nxt = DONE;
`endif
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        out_word  = '0;
        out_zero  = 1'b0;
        out_ovf   = 1'b0;
        out_unf   = 1'b0;
        if (state == DONE) begin
            out_word = {sign_r, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
            out_zero = zero_r;
            out_ovf  = ovf_r;
            out_unf  = unf_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r <= 1'b0;
            exp_r  <= '0;
            mant_r <= '0;
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                sign_r <= in_sign;
                exp_r  <= {1'b0, in_exp};
                mant_r <= in_mant;
                zero_r <= 1'b0;
                ovf_r  <= 1'b0;
                unf_r  <= 1'b0;
            end
        end else if (state == NORM) begin
            if (mant_r == '0) begin
                zero_r <= 1'b1;
                exp_r  <= '0;
            end else if (exp_r == EXP_SAT) begin
                ovf_r  <= 1'b1;
                mant_r <= '0;
            end else if (mant_r[MAN_W+1]) begin
                // Truncating carry shift; landing on 255 becomes infinity.
                exp_r  <= exp_inc;
                mant_r <= mant_r >> 1;
                if (exp_inc == EXP_SAT) begin
                    ovf_r  <= 1'b1;
                    mant_r <= '0;
                end
`ifdef FP_NORM_FAST_SHIFT_EN
            end else if (lz != 5'd0 && {4'b0, lz} >= exp_r) begin
                // lz==0 is already normalized and never flushes, matching serial.
                unf_r  <= 1'b1;
                exp_r  <= '0;
                mant_r <= '0;
            end else begin
                mant_r <= mant_r << lz;
                exp_r  <= exp_r - {4'b0, lz};
            end
`else
            end else if (mant_r[MAN_W]) begin
                mant_r <= mant_r;
            end else if (exp_r <= 9'd1) begin
                unf_r  <= 1'b1;
                exp_r  <= '0;
                mant_r <= '0;
            end else begin
                mant_r <= mant_r << 1;
                exp_r  <= exp_r - 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed table-driven bench for fp_normalize_pack: result word, flags,
// latency, output hold under back-pressure and mid-operation reset.
module tb_fp_normalize_pack;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid, out_ready;
    logic [31:0] out_word;
    logic        out_zero, out_ovf, out_unf;

    int errors = 0;
    int checks = 0;

    fp_normalize_pack dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_zero(out_zero),
        .out_ovf(out_ovf), .out_unf(out_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        logic [31:0] word;
        logic        zero, ovf, unf;
        int          lat_ser;
        int          lat_fast;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int lat;
        logic [31:0] w0;
        @(negedge clk);
        chk($sformatf("v%0d in_ready idle", idx), {31'b0, in_ready}, 32'd1);
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_mant  = v.mant;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
`ifdef FP_NORM_FAST_SHIFT_EN
        lat = v.lat_fast;
`else
        lat = v.lat_ser;
`endif
        n = 1;
        forever begin
            @(negedge clk);
            if (out_valid || n > 40) break;
            chk($sformatf("v%0d in_ready busy", idx), {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            n++;
        end
        chk($sformatf("v%0d latency", idx), n, lat);
        if (!out_valid) return;
        chk($sformatf("v%0d word", idx), out_word, v.word);
        chk($sformatf("v%0d flags zou", idx), {29'b0, out_zero, out_ovf, out_unf},
            {29'b0, v.zero, v.ovf, v.unf});
        w0 = out_word;
        // Back-pressure with a competing input present: nothing may move.
        for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'b1;
            in_sign  = ~v.sign;
            in_exp   = 8'h7F;
            in_mant  = 25'h0800000;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d hold%0d word", idx, h), out_word, w0);
            chk($sformatf("v%0d hold%0d flags", idx, h),
                {28'b0, out_valid, out_zero, out_ovf, out_unf},
                {28'b0, 1'b1, v.zero, v.ovf, v.unf});
            chk($sformatf("v%0d hold%0d in_ready", idx, h), {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk($sformatf("v%0d release vld/rdy", idx), {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    vec_t vecs[11];

    initial begin
        //        sign  exp    mant         word          z     o     u    ser fast hold
        vecs[0]  = '{1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 1'b0, 1'b0, 1'b0,  2, 2, 0};
        vecs[1]  = '{1'b0, 8'h80, 25'h1800000, 32'h40C00000, 1'b0, 1'b0, 1'b0,  2, 2, 0};
        vecs[2]  = '{1'b0, 8'h85, 25'h0100000, 32'h41000000, 1'b0, 1'b0, 1'b0,  5, 2, 0};
        vecs[3]  = '{1'b1, 8'h50, 25'h0000000, 32'h80000000, 1'b1, 1'b0, 1'b0,  2, 2, 0};
        vecs[4]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 1'b0, 1'b1, 1'b0,  2, 2, 0};
        vecs[5]  = '{1'b0, 8'h02, 25'h0200000, 32'h00000000, 1'b0, 1'b0, 1'b1,  3, 2, 5};
        vecs[6]  = '{1'b1, 8'hFF, 25'h0C00000, 32'hFF800000, 1'b0, 1'b1, 1'b0,  2, 2, 0};
        vecs[7]  = '{1'b0, 8'h7F, 25'h0000001, 32'h34000000, 1'b0, 1'b0, 1'b0, 25, 2, 0};
        vecs[8]  = '{1'b1, 8'h81, 25'h0400000, 32'hC0000000, 1'b0, 1'b0, 1'b0,  3, 2, 0};
        vecs[9]  = '{1'b1, 8'h01, 25'h0400000, 32'h80000000, 1'b0, 1'b0, 1'b1,  2, 2, 0};
        vecs[10] = '{1'b1, 8'h10, 25'h1FFFFFF, 32'h88FFFFFF, 1'b0, 1'b0, 1'b0,  2, 2, 2};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = '0; in_mant = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset outputs", {out_word[27:0], out_valid, out_zero, out_ovf, out_unf}, 32'd0);
        chk("reset word/in_ready", {out_word[31:28], 27'b0, in_ready}, 32'd1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Reset during the third serial shift cycle abandons the operation.
        @(negedge clk);
        in_sign = 1'b1; in_exp = 8'h85; in_mant = 25'h0100000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midreset out_word", out_word, 32'd0);
        chk("midreset vld/rdy/flags", {27'b0, out_valid, in_ready, out_zero, out_ovf, out_unf},
            32'b01000);
        repeat (3) @(posedge clk);
        #1 chk("midreset no emit", {31'b0, out_valid}, 32'd0);
        run_vec(vecs[0], 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fp_normalize_pack.md
# fp_normalize_pack

Sequential normalize-and-pack stage sitting directly downstream of the floating-point add/subtract datapath. It accepts one raw result (sign, biased exponent, unnormalized 25-bit significand including carry and hidden bit) over a valid/ready handshake. It renormalizes the significand (one right shift for carry-out, iterative left shifts for cancellation) and packs an IEEE-754 single-precision word with zero/overflow/underflow flags. Consumers see a held, back-pressurable result.

## Interface
Parameters:
- none (widths fixed by package constants: EXP_W=8, MAN_W=23)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  raw result present
- in_ready  out  1  stage can accept; high only in IDLE
- in_sign  in  1  result sign
- in_exp  in  8  biased exponent of raw result
- in_mant  in  25  bit24 carry, bit23 hidden bit, bits22:0 fraction
- out_valid  out  1  packed result available
- out_ready  in  1  consumer accepts result
- out_word  out  32  {sign, exp[7:0], frac[22:0]}
- out_zero  out  1  result is signed zero from zero significand
- out_ovf  out  1  exponent overflow; out_word = signed infinity
- out_unf  out  1  exponent underflow; out_word flushed to signed zero

## Operation
- FSM states: IDLE, NORM, DONE.
- IDLE: in_ready=1. On in_valid: latch sign/exp/mant, clear flags, go to NORM.
- NORM evaluates in this priority order each cycle:
  - mant==0: out_zero=1, exp=0, go DONE.
  - in_exp==255 latched: out_ovf=1, go DONE.
  - mant[24]=1: mant>>=1 (truncate, no rounding); exp+=1. If the new exp==255: out_ovf=1, frac=0. Go DONE.
  - mant[23]=1: go DONE.
  - exp<=1: out_unf=1, exp=0, frac=0, go DONE.
  - else: mant<<=1, exp-=1, stay in NORM.
- DONE: out_valid=1, out_word={sign, exp, mant[22:0]}. Output and flags stay stable until out_ready. On out_ready, return to IDLE.
- Sign always passes through unchanged, including zero, inf and flush results.
- Arithmetic: exp held in a 9-bit working register so that +1 and -1 never wrap. Significand 25 bits; bits shifted out are discarded.
- rst in any state: state=IDLE, in_ready=1 on the following cycle, out_valid=0, out_word=0, out_zero=out_ovf=out_unf=0, working registers=0. A reset during NORM abandons the operation without emitting a result.

## Timing
- Accept edge = E0. Without left shifts (normal, carry, zero, ovf): out_valid high from E2.
- k left shifts: out_valid from E(k+2). Worst case (mant=1) is k=23, giving E25.
- No overlap: in_ready=0 from E0 until the cycle after the out_ready handshake. Minimum initiation interval is 3 cycles.
- in_valid is ignored outside IDLE. The upstream stage holds its data until in_ready is seen.

## Configuration
- FP_NORM_FAST_SHIFT_EN defined:
  - NORM completes in exactly one cycle using a leading-zero count n of mant[23:0].
  - If n>=exp: underflow flush. Otherwise mant<<=n and exp-=n.
  - Carry, zero and overflow rules are unchanged.
  - out_valid is always at E2.
- FP_NORM_FAST_SHIFT_EN undefined: serial one-bit-per-cycle shifting as above. Results are bit-identical in both builds; only latency differs.

## Structure
- Package fp_pkg holds:
  - EXP_W, MAN_W, BIAS=127, EXP_MAX=255
  - state enum {IDLE, NORM, DONE}
  - constants POS_INF=32'h7F800000, NEG_INF=32'hFF800000
- Sub-module fp_lzc: combinational 24-bit leading-zero counter producing a 5-bit count. It is instantiated only under FP_NORM_FAST_SHIFT_EN.

## Test plan
- exp=0x7F, mant=0x0800000, sign=0 -> out_word=0x3F800000, all flags 0, out_valid at E2.
- exp=0x80, mant=0x1800000 (carry) -> out_word=0x40C00000, out_valid at E2.
- exp=0x85, mant=0x0100000 -> out_word=0x41000000. out_valid at E5 serial, E2 fast build.
- sign=1, mant=0 -> out_word=0x80000000, out_zero=1. Then exp=0xFE, mant=0x1000000 -> 0x7F800000, out_ovf=1.
- exp=0x02, mant=0x0200000 -> out_word=0x00000000, out_unf=1. Hold out_ready=0 for 5 cycles; out_word and flags must not change, and in_ready must stay 0.
- Assert rst during the third NORM shift cycle -> next cycle IDLE, out_valid=0, all outputs 0. A fresh 1.0 input then yields 0x3F800000.
